// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I constants for the fetch front end
package rv32i_pkg;
    localparam int          XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP                  = 32'h0000_0013;
    localparam logic [3:0]  IMEM_MASK_WORD       = 4'b1111;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO; flush overrides push/pop
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; entries are only observable while counted.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch front end: PC, single-outstanding imem reads, prefetch FIFO
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter int              FIFO_DEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_request,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_we_re,
    output logic [3:0]      imem_mask,
    input  logic            imem_valid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic            misalign
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   issued_pc;
    logic              outstanding;
    logic              drop;
    logic              issue;
    logic              accept;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [2*XLEN-1:0] fifo_head;

    assign issue        = !rst && !outstanding && !fifo_full && !redirect;
    assign accept       = imem_valid && outstanding;
    assign push         = accept && !drop && !redirect;
    assign pop          = dec_valid && dec_ready;

    assign imem_request = issue;
    assign imem_addr    = fetch_pc;
    assign imem_we_re   = 1'b0;
    assign imem_mask    = IMEM_MASK_WORD;

    assign dec_valid    = (fifo_count != '0);
    assign dec_pc       = fifo_empty ? '0 : fifo_head[2*XLEN-1:XLEN];
    assign dec_instr    = fifo_empty ? '0 : fifo_head[XLEN-1:0];
    assign misalign     = !rst && redirect && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_VECTOR;
            issued_pc   <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            // A response landing with the redirect is the one in flight, so
            // nothing remains to drop afterwards.
            if (accept) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end else if (outstanding) begin
                drop <= 1'b1;
            end
        end else begin
            if (issue) begin
                outstanding <= 1'b1;
                issued_pc   <= fetch_pc;
                fetch_pc    <= fetch_pc + XLEN'(4);
            end
            if (accept) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({issued_pc, imem_rdata}),
        .pop       (pop),
        .flush     (redirect),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit (default and wrapping reset vector)
module tb_fetch_unit;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_ready;

    logic        imem_request, imem_we_re, dec_valid, misalign;
    logic [31:0] imem_addr, dec_instr, dec_pc;
    logic [3:0]  imem_mask;

    logic        w_imem_request, w_imem_we_re, w_dec_valid, w_misalign;
    logic [31:0] w_imem_addr, w_dec_instr, w_dec_pc;
    logic [3:0]  w_imem_mask;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [31:0] I0    = 32'h0010_0093;
    localparam logic [31:0] I1    = 32'h0020_0113;
    localparam logic [31:0] I2    = 32'h0030_0193;
    localparam logic [31:0] I3    = 32'h0040_0213;
    localparam logic [31:0] I4    = 32'h0050_0293;
    localparam logic [31:0] STALE = 32'hDEAD_BEEF;
    localparam logic [31:0] JUNK  = 32'hBAAD_F00D;
    localparam logic [31:0] I100  = 32'h1000_0117;
    localparam logic [31:0] I200  = 32'h2000_0217;
    localparam logic [31:0] I104  = 32'h1040_0317;
    localparam logic [31:0] LATE  = 32'hCAFE_0001;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_request(imem_request), .imem_addr(imem_addr),
        .imem_we_re(imem_we_re), .imem_mask(imem_mask),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .misalign(misalign)
    );

    fetch_unit #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_request(w_imem_request), .imem_addr(w_imem_addr),
        .imem_we_re(w_imem_we_re), .imem_mask(w_imem_mask),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .dec_valid(w_dec_valid), .dec_ready(dec_ready),
        .dec_instr(w_dec_instr), .dec_pc(w_dec_pc), .misalign(w_misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, then let outputs settle.
    task automatic cyc(input logic r, input logic v, input logic [31:0] d,
                       input logic rd, input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        rst         = r;
        imem_valid  = v;
        imem_rdata  = d;
        redirect    = rd;
        redirect_pc = rpc;
        dec_ready   = rdy;
        #1;
    endtask

    initial begin
        rst = 1'b1; imem_valid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b1;

        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        chk("rst_request", imem_request, 0);
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_dec_pc", dec_pc, 0);
        chk("rst_dec_instr", dec_instr, 0);
        chk("rst_misalign", misalign, 0);
        chk("we_re", imem_we_re, 0);
        chk("mask", imem_mask, 4'hF);

        cyc(0, 0, 0, 0, 0, 1);
        chk("c0_request", imem_request, 1);
        chk("c0_addr", imem_addr, 32'h0);
        chk("c0_wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
        cyc(0, 1, I0, 0, 0, 1);
        chk("c1_request", imem_request, 0);
        chk("c1_dec_valid", dec_valid, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("c2_dec_valid", dec_valid, 1);
        chk("c2_dec_pc", dec_pc, 32'h0);
        chk("c2_dec_instr", dec_instr, I0);
        chk("c2_addr", imem_addr, 32'h4);
        chk("c2_wrap_addr", w_imem_addr, 32'h0);
        chk("c2_wrap_dec_pc", w_dec_pc, 32'hFFFF_FFFC);
        cyc(0, 1, I1, 0, 0, 1);
        chk("c3_dec_valid", dec_valid, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("c4_dec_pc", dec_pc, 32'h4);
        chk("c4_dec_instr", dec_instr, I1);
        chk("c4_addr", imem_addr, 32'h8);
        cyc(0, 1, I2, 0, 0, 1);

        cyc(0, 0, 0, 0, 0, 0);
        chk("stall_dec_pc", dec_pc, 32'h8);
        chk("stall_request", imem_request, 1);
        chk("stall_addr", imem_addr, 32'hC);
        cyc(0, 1, I3, 0, 0, 0);
        chk("stall2_request", imem_request, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("full_request", imem_request, 0);
        chk("full_dec_pc", dec_pc, 32'h8);
        cyc(0, 0, 0, 0, 0, 1);
        chk("release_request", imem_request, 0);
        chk("release_dec_instr", dec_instr, I2);
        cyc(0, 0, 0, 0, 0, 1);
        chk("release_dec_pc2", dec_pc, 32'hC);
        chk("release_dec_instr2", dec_instr, I3);
        chk("resume_addr", imem_addr, 32'h10);
        chk("resume_request", imem_request, 1);
        cyc(0, 1, I4, 0, 0, 1);
        chk("c11_dec_valid", dec_valid, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("c12_dec_pc", dec_pc, 32'h10);
        chk("c12_addr", imem_addr, 32'h14);

        cyc(0, 0, 0, 1, 32'h100, 1);
        chk("redir_request", imem_request, 0);
        chk("redir_misalign", misalign, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("redir_wait_request", imem_request, 0);
        chk("redir_flushed", dec_valid, 0);
        cyc(0, 1, STALE, 0, 0, 1);
        chk("stale_cycle_request", imem_request, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("stale_dropped", dec_valid, 0);
        chk("target_request", imem_request, 1);
        chk("target_addr", imem_addr, 32'h100);
        cyc(0, 1, I100, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("target_dec_pc", dec_pc, 32'h100);
        chk("target_dec_instr", dec_instr, I100);
        chk("c18_addr", imem_addr, 32'h104);

        cyc(0, 1, JUNK, 1, 32'h200, 1);
        chk("coinc_request", imem_request, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("coinc_dec_valid", dec_valid, 0);
        chk("coinc_next_request", imem_request, 1);
        chk("coinc_next_addr", imem_addr, 32'h200);
        cyc(0, 1, I200, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("coinc_accept_valid", dec_valid, 1);
        chk("coinc_accept_pc", dec_pc, 32'h200);
        chk("coinc_accept_instr", dec_instr, I200);
        cyc(0, 1, 32'h2040_0017, 0, 0, 1);

        cyc(0, 0, 0, 1, 32'h106, 1);
        chk("mis_pulse", misalign, 1);
        chk("mis_request", imem_request, 0);
        chk("mis_wrap_pulse", w_misalign, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("mis_end", misalign, 0);
        chk("mis_flushed", dec_valid, 0);
        chk("mis_addr", imem_addr, 32'h104);
        cyc(0, 1, I104, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("mis_dec_pc", dec_pc, 32'h104);
        chk("mis_dec_instr", dec_instr, I104);

        cyc(1, 0, 0, 0, 0, 1);
        chk("midrst_request", imem_request, 0);
        cyc(0, 1, LATE, 0, 0, 1);
        chk("postrst_request", imem_request, 1);
        chk("postrst_addr", imem_addr, 32'h0);
        chk("postrst_wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0, 1);
        chk("late_ignored", dec_valid, 0);
        chk("late_wrap_ignored", w_dec_valid, 0);
        cyc(0, 1, NOP, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("postrst_dec_valid", dec_valid, 1);
        chk("postrst_dec_pc", dec_pc, 32'h0);
        chk("postrst_dec_instr", dec_instr, NOP);
        chk("postrst_wrap_dec_pc", w_dec_pc, 32'hFFFF_FFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
